// File: rtl/change_dispenser_if.sv
// Bus bundle for the change dispenser: payout request, inventory load,
// the two 4-phase hopper handshakes and the status outputs.
interface change_dispenser_if;
  logic       req_valid;
  logic [7:0] req_amount;
  logic       req_ready;
  logic       load_en;
  logic [7:0] load_n10;
  logic [7:0] load_n5;
  logic       coin10_req;
  logic       coin5_req;
  logic       coin10_ack;
  logic       coin5_ack;
  logic [7:0] inv10;
  logic [7:0] inv5;
  logic       busy;
  logic       done;
  logic [7:0] remain;
  logic       short;
  logic       jam;

  // Environment side: issues requests, loads coins, answers as the hoppers.
  modport master (
    output req_valid, req_amount, load_en, load_n10, load_n5, coin10_ack, coin5_ack,
    input  req_ready, coin10_req, coin5_req, inv10, inv5, busy, done, remain, short, jam
  );

  // Dispenser side.
  modport slave (
    input  req_valid, req_amount, load_en, load_n10, load_n5, coin10_ack, coin5_ack,
    output req_ready, coin10_req, coin5_req, inv10, inv5, busy, done, remain, short, jam
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays a request in units of 5 using 10-coins first,
// then 5-coins, with a per-phase timeout on each hopper handshake.
module change_dispenser #(
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               reset_n,
  change_dispenser_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, PAY10, ACK10, REL10, PAY5, ACK5, REL5, DONE
  } state_e;

  // The counter is compared against the last permitted cycle index, so a
  // phase lasts exactly TIMEOUT cycles before jam is declared.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] inv10_q, inv10_d;
  logic [7:0] inv5_q, inv5_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] remain_q, remain_d;
  logic       short_q, short_d;
  logic       jam_q, jam_d;
  logic       c10_q, c10_d;
  logic       c5_q, c5_d;
  logic       done_q, done_d;
  logic       req_ready;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Ready only when idle and no load competes for the same cycle.
  assign req_ready      = reset_n && (state_q == IDLE) && !bus.load_en;
  assign bus.req_ready  = req_ready;
  assign bus.busy       = (state_q != IDLE);
  assign bus.coin10_req = c10_q;
  assign bus.coin5_req  = c5_q;
  assign bus.inv10      = inv10_q;
  assign bus.inv5       = inv5_q;
  assign bus.done       = done_q;
  assign bus.remain     = remain_q;
  assign bus.short      = short_q;
  assign bus.jam        = jam_q;

  // Next-state, inventory/remainder bookkeeping and registered-output decode.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    inv10_d  = inv10_q;
    inv5_d   = inv5_q;
    cnt_d    = 8'd0;
    remain_d = remain_q;
    short_d  = short_q;
    jam_d    = jam_q;
    case (state_q)
      IDLE: begin
        if (bus.load_en) begin
          inv10_d = sat_add(inv10_q, bus.load_n10);
          inv5_d  = sat_add(inv5_q, bus.load_n5);
        end else if (bus.req_valid) begin
          rem_d   = bus.req_amount;
          jam_d   = 1'b0;
          state_d = PAY10;
        end
      end
      PAY10: state_d = (rem_q >= 8'd2 && inv10_q != 8'd0) ? ACK10 : PAY5;
      ACK10: begin
        if (bus.coin10_ack) begin
          inv10_d = inv10_q - 8'd1;
          rem_d   = rem_q - 8'd2;
          state_d = REL10;
        end else if (cnt_q == TMO_LAST) begin
          jam_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REL10: begin
        if (!bus.coin10_ack) begin
          state_d = PAY10;
        end else if (cnt_q == TMO_LAST) begin
          jam_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PAY5: state_d = (rem_q >= 8'd1 && inv5_q != 8'd0) ? ACK5 : DONE;
      ACK5: begin
        if (bus.coin5_ack) begin
          inv5_d  = inv5_q - 8'd1;
          rem_d   = rem_q - 8'd1;
          state_d = REL5;
        end else if (cnt_q == TMO_LAST) begin
          jam_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REL5: begin
        if (!bus.coin5_ack) begin
          state_d = PAY5;
        end else if (cnt_q == TMO_LAST) begin
          jam_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Result is published on entry to DONE so it is valid alongside done.
    if (state_d == DONE) begin
      remain_d = rem_d;
      short_d  = (rem_d != 8'd0);
    end
    c10_d  = (state_d == ACK10);
    c5_d   = (state_d == ACK5);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset drops any in-flight coin request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rem_q    <= 8'd0;
      inv10_q  <= 8'd0;
      inv5_q   <= 8'd0;
      cnt_q    <= 8'd0;
      remain_q <= 8'd0;
      short_q  <= 1'b0;
      jam_q    <= 1'b0;
      c10_q    <= 1'b0;
      c5_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      inv10_q  <= inv10_d;
      inv5_q   <= inv5_d;
      cnt_q    <= cnt_d;
      remain_q <= remain_d;
      short_q  <= short_d;
      jam_q    <= jam_d;
      c10_q    <= c10_d;
      c5_q     <= c5_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: transaction-level payout model, randomized
// hopper responders with injectable stalls, per-cycle output checking.
module tb_change_dispenser;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  change_dispenser_if dif();

  change_dispenser #(.TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif.slave)
  );

  logic ack_r [2] = '{1'b0, 1'b0};
  assign dif.coin10_ack = ack_r[0];
  assign dif.coin5_ack  = ack_r[1];

  int n_cmp = 0, n_bad = 0;
  int m10 = 0, m5 = 0;
  int exp_rem = 0;
  int exp_jam = 0;
  int pay10 = 0, pay5 = 0;
  int done_cnt = 0, busy_cyc = 0, c10_cyc = 0, c5_cyc = 0;
  int coins_seen = 0;
  int seen [2] = '{0, 0};
  int stall_mode = 0, stall_k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic hreq(input int h);
    return (h == 0) ? dif.coin10_req : dif.coin5_req;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hopper: acks after a short random delay; stall_mode 1 withholds the ack
  // for coin stall_k, stall_mode 2 holds the ack too long after release.
  task automatic hopper(input int h);
    int ord, d, hold, guard;
    forever begin
      tick();
      if (hreq(h) && !ack_r[h]) begin
        ord = coins_seen;
        if (!(stall_mode == 1 && ord == stall_k)) begin
          d = $urandom_range(0, 3);
          repeat (d) tick();
          if (hreq(h)) begin
            ack_r[h] = 1'b1;
            coins_seen++;
            seen[h]++;
            hold = (stall_mode == 2 && ord == stall_k) ? TIMEOUT + 4 : $urandom_range(0, 3);
            guard = 0;
            while (hreq(h) && guard < 50) begin tick(); guard++; end
            repeat (hold) tick();
            ack_r[h] = 1'b0;
          end
        end
      end
    end
  endtask

  initial hopper(0);
  initial hopper(1);

  // Per-cycle checker against the model.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_flags", {dif.req_ready, dif.coin10_req, dif.coin5_req, dif.busy,
                        dif.done, dif.short, dif.jam}, 0);
      chk("rst_inv10", dif.inv10, 0);
      chk("rst_inv5", dif.inv5, 0);
      chk("rst_remain", dif.remain, 0);
    end else begin
      chk("one_hopper", dif.coin10_req && dif.coin5_req, 0);
      chk("req_ready", dif.req_ready, !dif.busy && !dif.load_en);
      if (dif.busy) busy_cyc++;
      if (dif.coin10_req) c10_cyc++;
      if (dif.coin5_req) c5_cyc++;
      if (dif.done) begin
        done_cnt++;
        chk("done_busy", dif.busy, 1);
        chk("done_remain", dif.remain, exp_rem);
        chk("done_short", dif.short, exp_rem != 0);
        chk("done_jam", dif.jam, exp_jam);
        chk("done_inv10", dif.inv10, m10);
        chk("done_inv5", dif.inv5, m5);
      end else if (!dif.busy) begin
        chk("idle_inv10", dif.inv10, m10);
        chk("idle_inv5", dif.inv5, m5);
        chk("idle_remain", dif.remain, exp_rem);
        chk("idle_short", dif.short, exp_rem != 0);
        chk("idle_jam", dif.jam, exp_jam);
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    dif.req_valid = 1'b0;
    dif.load_en = 1'b0;
    m10 = 0; m5 = 0; exp_rem = 0; exp_jam = 0; stall_mode = 0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic load(input int a, input int b);
    dif.load_en = 1'b1;
    dif.load_n10 = 8'(a);
    dif.load_n5 = 8'(b);
    tick();
    m10 = imin(255, m10 + a);
    m5 = imin(255, m5 + b);
    dif.load_en = 1'b0;
  endtask

  // Work out the payout from the rules: tens first, then fives, truncated at
  // the stalled coin. Arms the hoppers and clears the per-request counters.
  task automatic prep(input int amt, input int mode, input int k);
    int t10, t5, tot, paid, g;
    t10 = imin(amt / 2, m10);
    t5 = imin(amt - 2 * t10, m5);
    tot = t10 + t5;
    if (mode != 0 && k >= tot) mode = 0;
    paid = (mode == 0) ? tot : (mode == 1) ? k : k + 1;
    pay10 = imin(paid, t10);
    pay5 = paid - pay10;
    g = 0;
    while ((!dif.req_ready || ack_r[0] || ack_r[1]) && g < 100) begin tick(); g++; end
    chk("idle_before_req", g < 100, 1);
    stall_mode = mode; stall_k = k; coins_seen = 0;
    seen[0] = 0; seen[1] = 0;
    busy_cyc = 0; c10_cyc = 0; c5_cyc = 0;
  endtask

  // Called right after the accept edge; commits the model and awaits done.
  task automatic finish(input int amt, input int dc);
    int g;
    exp_rem = amt - 2 * pay10 - pay5;
    exp_jam = (stall_mode != 0);
    m10 -= pay10;
    m5 -= pay5;
    g = 0;
    while (done_cnt == dc && g < 3000) begin tick(); g++; end
    tick();
    chk("done_pulses", done_cnt - dc, 1);
    chk("coins10", seen[0], pay10);
    chk("coins5", seen[1], pay5);
    stall_mode = 0;
  endtask

  task automatic issue(input int amt, input int mode, input int k);
    int dc;
    prep(amt, mode, k);
    dc = done_cnt;
    dif.req_valid = 1'b1;
    dif.req_amount = 8'(amt);
    tick();
    dif.req_valid = 1'b0;
    finish(amt, dc);
  endtask

  initial begin
    int g, dc, amt, mode;
    dif.req_valid = 1'b0; dif.req_amount = 8'd0;
    dif.load_en = 1'b0; dif.load_n10 = 8'd0; dif.load_n5 = 8'd0;
    do_reset();
    chk("reset_ready", dif.req_ready, 1);
    chk("reset_inv10", dif.inv10, 0);

    // 3 tens, 4 fives, request 7
    load(3, 4);
    issue(7, 0, 0);
    chk("r34_n10", seen[0], 3);
    chk("r34_n5", seen[1], 1);
    chk("r34_remain", dif.remain, 0);
    chk("r34_short", dif.short, 0);
    chk("r34_inv10", dif.inv10, 0);
    chk("r34_inv5", dif.inv5, 3);

    // only tens available, odd request
    do_reset();
    load(5, 0);
    issue(5, 0, 0);
    chk("r35_n10", seen[0], 2);
    chk("r35_n5", seen[1], 0);
    chk("r35_remain", dif.remain, 1);
    chk("r35_short", dif.short, 1);
    chk("r35_inv10", dif.inv10, 3);

    // zero request
    issue(0, 0, 0);
    chk("r36_busy_cycles", busy_cyc, 3);
    chk("r36_coin_cycles", c10_cyc + c5_cyc, 0);
    chk("r36_remain", dif.remain, 0);
    chk("r36_short", dif.short, 0);

    // hopper never acks: timeout
    do_reset();
    load(1, 0);
    issue(2, 1, 0);
    chk("r37_req_cycles", c10_cyc, TIMEOUT);
    chk("r37_coin10_low", dif.coin10_req, 0);
    chk("r37_jam", dif.jam, 1);
    chk("r37_remain", dif.remain, 2);
    chk("r37_inv10", dif.inv10, 1);

    // reset in the middle of a coin handshake
    do_reset();
    load(1, 0);
    stall_mode = 1; stall_k = 0; coins_seen = 0;
    dif.req_valid = 1'b1; dif.req_amount = 8'd2;
    tick();
    dif.req_valid = 1'b0;
    g = 0;
    while (!dif.coin10_req && g < 20) begin tick(); g++; end
    chk("r38_coin10_seen", dif.coin10_req, 1);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("r38_coin10_drop", dif.coin10_req, 0);
    chk("r38_busy", dif.busy, 0);
    chk("r38_inv10", dif.inv10, 0);
    m10 = 0; m5 = 0; exp_rem = 0; exp_jam = 0; stall_mode = 0;
    tick();
    reset_n = 1'b1;
    tick();

    // load and request in the same cycle: load wins, request waits a cycle
    prep(4, 0, 0);
    dc = done_cnt;
    dif.load_en = 1'b1; dif.load_n10 = 8'd2; dif.load_n5 = 8'd0;
    dif.req_valid = 1'b1; dif.req_amount = 8'd4;
    tick();
    m10 = 2;
    dif.load_en = 1'b0;
    chk("r38_not_accepted", dif.busy, 0);
    chk("r38_loaded", dif.inv10, 2);
    pay10 = 2; pay5 = 0;
    tick();
    dif.req_valid = 1'b0;
    chk("r38_accepted", dif.busy, 1);
    finish(4, dc);
    chk("r38_inv10_after", dif.inv10, 0);

    // saturation
    do_reset();
    load(0, 250);
    load(0, 10);
    chk("r39_inv5_sat", dif.inv5, 255);
    load(255, 3);
    chk("r39_inv10", dif.inv10, 255);
    chk("r39_inv5_hold", dif.inv5, 255);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, 12), $urandom_range(0, 12));
      amt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 25);
      mode = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
      issue(amt, mode, $urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter: TIMEOUT, 200, max cycles any coin handshake phase may wait before jam is declared (range 2..255).
REQ-002 clk  in  1  clock; all logic on posedge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  payout request present.
REQ-005 req_amount  in  8  payout in units of 5 (0..255).
REQ-006 req_ready  out  1  block accepts request this cycle.
REQ-007 load_en  in  1  add load_n10/load_n5 to coin inventory.
REQ-008 load_n10, load_n5  in  8 each  coins added to 10-hopper / 5-hopper.
REQ-009 coin10_req, coin5_req  out  1 each  hopper eject request, held until ack.
REQ-010 coin10_ack, coin5_ack  in  1 each  hopper acknowledge, 4-phase.
REQ-011 inv10, inv5  out  8 each  current hopper inventory.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 done  out  1  one-cycle pulse at end of every accepted request.
REQ-014 remain  out  8  unpaid units of 5 for last request, valid from done until next accept.
REQ-015 short  out  1  remain != 0, valid with remain.
REQ-016 jam  out  1  sticky; set on handshake timeout, cleared only at next accept.

Function
REQ-017 States: IDLE, PAY10, ACK10, REL10, PAY5, ACK5, REL5, DONE.
REQ-018 req_ready SHALL be 1 only in IDLE with load_en=0; load takes priority over a simultaneous request.
REQ-019 On req_valid&&req_ready: latch rem<=req_amount, clear jam, go to PAY10 next cycle.
REQ-020 load_en in IDLE: inv10+=load_n10, inv5+=load_n5 next edge, each saturating at 255; load_en outside IDLE is ignored.
REQ-021 PAY10: if rem>=2 and inv10>0 go ACK10, else go PAY5; no coin request asserted in PAY10.
REQ-022 ACK10: coin10_req=1; on coin10_ack sampled 1: inv10-=1, rem-=2, go REL10.
REQ-023 REL10: coin10_req=0; on coin10_ack sampled 0 go PAY10.
REQ-024 PAY5/ACK5/REL5 mirror REQ-021..023 with condition rem>=1 and inv5>0, decrement rem by 1; PAY5 with condition false goes DONE.
REQ-025 Greedy order: all 10-coins first, then 5-coins; a 5-coin is used for an odd unit or when inv10 exhausts.
REQ-026 Timeout: per-phase counter cleared on entering ACKx/RELx; reaching TIMEOUT cycles in a state without the awaited ack level sets jam=1, drops req, goes DONE; no inventory or rem change for that coin.
REQ-027 DONE: done=1 for exactly one cycle, remain<=rem, short<=(rem!=0), next state IDLE.
REQ-028 req_amount=0: PAY10->PAY5->DONE, no coin request; done two cycles after accept... plus DONE cycle, i.e. done high on 3rd cycle after accept edge.
REQ-029 coin10_req and coin5_req SHALL never be high simultaneously; both are registered outputs, glitch-free.
REQ-030 rem never underflows; arithmetic 8-bit unsigned.
REQ-031 Ack asserted while not in an ACK state is ignored.

Reset
REQ-032 reset_n low SHALL asynchronously force state IDLE and all outputs 0 (req_ready becomes 1 after release if load_en=0), inv10=inv5=0, rem=0, jam=0.
REQ-033 Reset mid-payment drops coin request immediately; the in-flight coin is not counted.

Verification
REQ-034 Load 3 tens, 4 fives; request 7 -> three coin10 handshakes, one coin5; remain=0, short=0, inv10=0, inv5=3.
REQ-035 inv10=5, inv5=0; request 5 -> two coin10 handshakes, no coin5; remain=1, short=1, inv10=3.
REQ-036 Request 0 -> no coin_req, single done pulse, remain=0, short=0, busy high 3 cycles.
REQ-037 TIMEOUT=8, inv10=1, request 2, ack held 0 -> coin10_req high 8 cycles then low, jam=1, done, remain=2, inv10=1.
REQ-038 reset_n pulsed low in ACK10 -> coin10_req low same cycle, inv10=0, busy=0; load_en with req_valid same cycle -> load applied, request not accepted until next cycle.
REQ-039 inv5=250, load_n5=10 -> inv5=255 (saturation).
